// File: rtl/cp0_unit.sv
// Coprocessor-0 for the M stage: SR/Cause/EPC, exception and interrupt request, mfc0 reads.
// Optional feature: define CP0_PRID_EN to make register 15 read back PRID_VALUE.
module cp0_unit #(
    parameter logic [31:0] PRID_VALUE = 32'h2023_0007
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic        req,
    output logic [31:0] cp0_rdata,
    output logic [31:0] epc_out
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    logic [5:0]  sr_im_reg,     sr_im_next;
    logic        sr_exl_reg,    sr_exl_next;
    logic        sr_ie_reg,     sr_ie_next;
    logic        cause_bd_reg,  cause_bd_next;
    logic [5:0]  cause_ip_reg,  cause_ip_next;
    logic [4:0]  cause_exc_reg, cause_exc_next;
    logic [31:0] epc_reg,       epc_next;

    logic [5:0]  int_pend;
    logic        int_req;
    logic        exc_req;
    logic        sr_wr;
    logic        epc_wr;
    logic [31:0] sr_value;
    logic [31:0] cause_value;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_int_pend
            assign int_pend[gi] = hw_int[gi] & sr_im_reg[gi];
        end
    endgenerate

    // EXL masks both sources, so nothing nests inside a handler.
    assign int_req = (|int_pend) & sr_ie_reg & ~sr_exl_reg;
    assign exc_req = (exc_code_in != 5'd0) & ~sr_exl_reg;
    assign req     = int_req | exc_req;

    // A taken request discards any mtc0 issued alongside it.
    assign sr_wr  = we & ~req & (addr == ADDR_SR);
    assign epc_wr = we & ~req & (addr == ADDR_EPC);

    always_comb begin
        sr_im_next     = sr_im_reg;
        sr_exl_next    = sr_exl_reg;
        sr_ie_next     = sr_ie_reg;
        cause_bd_next  = cause_bd_reg;
        cause_ip_next  = hw_int;
        cause_exc_next = cause_exc_reg;
        epc_next       = epc_reg;

        if (sr_wr) begin
            sr_im_next  = wdata[15:10];
            sr_exl_next = wdata[1];
            sr_ie_next  = wdata[0];
        end
        if (epc_wr) begin
            epc_next = wdata;
        end

        // eret overrides an SR write for EXL, but a request overrides eret.
        if (req) begin
            sr_exl_next    = 1'b1;
            cause_exc_next = int_req ? 5'd0 : exc_code_in;
            cause_bd_next  = bd_in;
            epc_next       = bd_in ? (vpc - 32'd4) : vpc;
        end else if (eret) begin
            sr_exl_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im_reg     <= 6'd0;
            sr_exl_reg    <= 1'b0;
            sr_ie_reg     <= 1'b0;
            cause_bd_reg  <= 1'b0;
            cause_ip_reg  <= 6'd0;
            cause_exc_reg <= 5'd0;
            epc_reg       <= 32'd0;
        end else begin
            sr_im_reg     <= sr_im_next;
            sr_exl_reg    <= sr_exl_next;
            sr_ie_reg     <= sr_ie_next;
            cause_bd_reg  <= cause_bd_next;
            cause_ip_reg  <= cause_ip_next;
            cause_exc_reg <= cause_exc_next;
            epc_reg       <= epc_next;
        end
    end

    assign sr_value    = {16'd0, sr_im_reg, 8'd0, sr_exl_reg, sr_ie_reg};
    assign cause_value = {cause_bd_reg, 15'd0, cause_ip_reg, 3'd0, cause_exc_reg, 2'd0};

`ifdef CP0_PRID_EN
    always_comb begin
        cp0_rdata = 32'd0;
        case (addr)
            ADDR_SR:    cp0_rdata = sr_value;
            ADDR_CAUSE: cp0_rdata = cause_value;
            ADDR_EPC:   cp0_rdata = epc_reg;
            ADDR_PRID:  cp0_rdata = PRID_VALUE;
            default:    cp0_rdata = 32'd0;
        endcase
    end
`else
    logic unused_prid;
    assign unused_prid = (^PRID_VALUE) ^ (^ADDR_PRID);

    always_comb begin
        cp0_rdata = 32'd0;
        case (addr)
            ADDR_SR:    cp0_rdata = sr_value;
            ADDR_CAUSE: cp0_rdata = cause_value;
            ADDR_EPC:   cp0_rdata = epc_reg;
            default:    cp0_rdata = 32'd0;
        endcase
    end
`endif

    // Forward an in-flight EPC write so an eret right behind mtc0 sees it.
    assign epc_out = epc_wr ? wdata : epc_reg;

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: directed stimulus pushes expectations, a negedge monitor checks them.
module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        eret;
    logic        req;
    logic [31:0] cp0_rdata;
    logic [31:0] epc_out;

    cp0_unit dut (
        .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata),
        .vpc(vpc), .bd_in(bd_in), .exc_code_in(exc_code_in), .hw_int(hw_int),
        .eret(eret), .req(req), .cp0_rdata(cp0_rdata), .epc_out(epc_out)
    );

    always #5 clk = ~clk;

    localparam int SEL_RDATA = 0;
    localparam int SEL_REQ   = 1;
    localparam int SEL_EPC   = 2;

`ifdef CP0_PRID_EN
    localparam logic [31:0] PRID_EXP = 32'h2023_0007;
`else
    localparam logic [31:0] PRID_EXP = 32'h0000_0000;
`endif

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t sb_q[$];
    int   tests  = 0;
    int   failed = 0;

    // Monitor: outputs are combinational, so everything queued this cycle is checked at the negedge.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            chk_t        c;
            logic [31:0] act;
            c = sb_q.pop_front();
            case (c.sel)
                SEL_RDATA: act = cp0_rdata;
                SEL_REQ:   act = {31'd0, req};
                default:   act = epc_out;
            endcase
            tests++;
            if (act !== c.exp) begin
                failed++;
                $display("FAIL %s: got %08h expected %08h", c.name, act, c.exp);
            end else begin
                $display("ok   %s: %08h", c.name, act);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; addr = 5'd0; wdata = 32'd0; vpc = 32'd0; bd_in = 1'b0;
        exc_code_in = 5'd0; hw_int = 6'd0; eret = 1'b0;
    endtask

    task automatic exp_chk(input string name, input int sel, input logic [31:0] v);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = v;
        sb_q.push_back(c);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        cyc(); cyc();
        reset = 1'b0;

        // Reset state
        cyc(); addr = 12; exp_chk("rst_sr", SEL_RDATA, 32'h0); exp_chk("rst_req", SEL_REQ, 32'h0);
        exp_chk("rst_epc_out", SEL_EPC, 32'h0);
        cyc(); addr = 13; exp_chk("rst_cause", SEL_RDATA, 32'h0);
        cyc(); addr = 14; exp_chk("rst_epc", SEL_RDATA, 32'h0);
        cyc(); addr = 0; hw_int = 6'h3F; exp_chk("rst_req_hwint", SEL_REQ, 32'h0);

        // Interrupt
        cyc(); hw_int = 0; we = 1; addr = 12; wdata = 32'h0000_FC01;
        cyc(); we = 0; exp_chk("sr_write", SEL_RDATA, 32'h0000_FC01);
        cyc(); addr = 0; hw_int = 6'b000100; vpc = 32'h3010; exp_chk("int_req", SEL_REQ, 32'h1);
        cyc(); hw_int = 0; vpc = 0; addr = 12; exp_chk("int_sr", SEL_RDATA, 32'h0000_FC03);
        exp_chk("int_req_masked", SEL_REQ, 32'h0); exp_chk("int_epc", SEL_EPC, 32'h3010);
        cyc(); addr = 13; exp_chk("int_cause", SEL_RDATA, 32'h0);
        cyc(); addr = 0; eret = 1; exp_chk("eret1_req", SEL_REQ, 32'h0);
        cyc(); eret = 0; addr = 12; exp_chk("eret1_sr", SEL_RDATA, 32'h0000_FC01);

        // Exception in delay slot
        cyc(); addr = 0; exc_code_in = 10; vpc = 32'h3024; bd_in = 1; exp_chk("exc_req", SEL_REQ, 32'h1);
        cyc(); exc_code_in = 0; vpc = 0; bd_in = 0; addr = 13;
        exp_chk("exc_cause", SEL_RDATA, 32'h8000_0028); exp_chk("exc_epc", SEL_EPC, 32'h3020);
        exp_chk("exc_req_after", SEL_REQ, 32'h0);
        cyc(); addr = 12; exp_chk("exc_sr", SEL_RDATA, 32'h0000_FC03);

        // Masking while EXL, then eret re-enables
        cyc(); addr = 0; exc_code_in = 4; hw_int = 6'h3F; exp_chk("exl_mask", SEL_REQ, 32'h0);
        cyc(); exc_code_in = 0; eret = 1; exp_chk("exl_mask_eret", SEL_REQ, 32'h0);
        cyc(); eret = 0; addr = 12; vpc = 32'h3200;
        exp_chk("post_eret_sr", SEL_RDATA, 32'h0000_FC01); exp_chk("post_eret_req", SEL_REQ, 32'h1);
        cyc(); hw_int = 0; vpc = 0; addr = 13;
        exp_chk("ip_follow", SEL_RDATA, 32'h0000_FC00); exp_chk("int2_epc", SEL_EPC, 32'h3200);
        cyc(); addr = 0; eret = 1;

        // eret yields to a pending exception
        cyc(); exc_code_in = 8; vpc = 32'h3300; exp_chk("eret_vs_exc_req", SEL_REQ, 32'h1);
        cyc(); eret = 0; exc_code_in = 0; vpc = 0; addr = 12;
        exp_chk("eret_vs_exc_sr", SEL_RDATA, 32'h0000_FC03); exp_chk("eret_vs_exc_epc", SEL_EPC, 32'h3300);
        cyc(); addr = 13; exp_chk("eret_vs_exc_cause", SEL_RDATA, 32'h0000_0020);
        cyc(); addr = 0; eret = 1;

        // mtc0 EPC dropped under req
        cyc(); eret = 0; we = 1; addr = 14; wdata = 32'h4000; exc_code_in = 12; vpc = 32'h3100;
        exp_chk("drop_req", SEL_REQ, 32'h1); exp_chk("drop_no_fwd", SEL_EPC, 32'h3300);
        cyc(); we = 0; wdata = 0; exc_code_in = 0; vpc = 0;
        exp_chk("drop_epc", SEL_RDATA, 32'h3100); exp_chk("drop_epc_out", SEL_EPC, 32'h3100);
        cyc(); eret = 1;

        // EPC forwarding, no write-through on reads
        cyc(); eret = 0; we = 1; wdata = 32'hABCD_0000;
        exp_chk("fwd_epc_out", SEL_EPC, 32'hABCD_0000); exp_chk("fwd_no_wt", SEL_RDATA, 32'h3100);
        cyc(); we = 0; wdata = 0; exp_chk("mtc0_epc", SEL_RDATA, 32'hABCD_0000);

        // Delay slot at pc 0 wraps
        cyc(); addr = 0; exc_code_in = 1; bd_in = 1; exp_chk("wrap_req", SEL_REQ, 32'h1);
        cyc(); exc_code_in = 0; bd_in = 0; addr = 14; exp_chk("wrap_epc", SEL_RDATA, 32'hFFFF_FFFC);
        cyc(); addr = 13; exp_chk("wrap_cause", SEL_RDATA, 32'h8000_0004);
        cyc(); addr = 0; eret = 1;

        // Cause is not writable
        cyc(); eret = 0; we = 1; addr = 13; wdata = 32'hFFFF_FFFF;
        cyc(); we = 0; wdata = 0; exp_chk("cause_ro", SEL_RDATA, 32'h8000_0004);

        // PRID register
        cyc(); we = 1; addr = 15; wdata = 32'h1234;
        cyc(); we = 0; wdata = 0; exp_chk("prid", SEL_RDATA, PRID_EXP);

        // eret beats an SR write for EXL only
        cyc(); we = 1; addr = 12; wdata = 32'h0000_0403; eret = 1; exp_chk("sr_eret_req", SEL_REQ, 32'h0);
        cyc(); we = 0; wdata = 0; eret = 0; exp_chk("sr_eret", SEL_RDATA, 32'h0000_0401);

        // Reset in the same cycle as req
        cyc(); addr = 0; exc_code_in = 3; vpc = 32'h5000; reset = 1; exp_chk("rst_req_comb", SEL_REQ, 32'h1);
        cyc(); reset = 0; exc_code_in = 0; vpc = 0; addr = 14;
        exp_chk("rst_req_epc", SEL_RDATA, 32'h0); exp_chk("rst_req_epc_out", SEL_EPC, 32'h0);
        cyc(); addr = 12; exp_chk("rst_req_sr", SEL_RDATA, 32'h0);
        cyc(); addr = 13; exp_chk("rst_req_cause", SEL_RDATA, 32'h0);

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            failed++;
            tests++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
